// File: rtl/unlock_key_checker.sv
`timescale 1ns/1ps
// unlock_key_checker
// Accepts a 4-byte key (MSB byte first) over a valid/ready byte stream while
// the power-on lock register reports locked. A matching key produces a one-cycle
// unlock pulse. A wrong key produces a one-cycle fail pulse. Repeated wrong keys
// force a timed lockout.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for the first key byte (ready only while locked)
// COLLECT | bytes 1..3 of an attempt being gathered
// CHECK   | one cycle; unlock/fail pulse is visible, next state decided
// LOCKOUT | too many consecutive failures; input refused for a fixed time
module unlock_key_checker #(
    parameter logic [31:0] KEY            = 32'hA5C3_0F96,
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_data,
    output logic       key_ready,
    input  logic       locked,
    output logic       unlock,
    output logic       fail,
    output logic       lockout,
    output logic [3:0] fail_cnt
);

    localparam int              TW        = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TMR_LOAD  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]      FAIL_TRIP = 4'(MAX_FAIL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t        state_q;
    logic [1:0]    idx_q;
    logic          mismatch_q;
    logic [3:0]    fail_cnt_q;
    logic          unlock_q;
    logic          fail_q;
    logic          lockout_q;
    logic [TW-1:0] tmr_q;

    logic [7:0]    exp_byte;
    logic          byte_mismatch;
    logic          accept;
    logic          mismatch_d;
    logic [3:0]    fail_cnt_inc;

    // Ready only while waiting for bytes of an attempt, the part is locked, and not in reset
    assign key_ready = !reset && locked && ((state_q == IDLE) || (state_q == COLLECT));
    assign accept    = key_valid && key_ready;

    assign unlock   = unlock_q;
    assign fail     = fail_q;
    assign lockout  = lockout_q;
    assign fail_cnt = fail_cnt_q;

    // Expected byte for the current index, mismatch tracking, saturating failure increment
    always_comb begin
        exp_byte = KEY[31:24];
        case (idx_q)
            2'd0:    exp_byte = KEY[31:24];
            2'd1:    exp_byte = KEY[23:16];
            2'd2:    exp_byte = KEY[15:8];
            default: exp_byte = KEY[7:0];
        endcase
        byte_mismatch = (key_data != exp_byte);
        mismatch_d    = mismatch_q | byte_mismatch;
        fail_cnt_inc  = (fail_cnt_q == 4'hF) ? 4'hF : fail_cnt_q + 4'd1;
    end

    // Attempt sequencing, result pulses, failure count and lockout timer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            mismatch_q <= 1'b0;
            fail_cnt_q <= 4'd0;
            unlock_q   <= 1'b0;
            fail_q     <= 1'b0;
            lockout_q  <= 1'b0;
            tmr_q      <= '0;
        end else begin
            unlock_q <= 1'b0;
            fail_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        idx_q      <= 2'd1;
                        mismatch_q <= byte_mismatch;
                        state_q    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (!locked) begin
                        // Lock released mid-attempt: drop the partial key, keep the count
                        idx_q      <= 2'd0;
                        mismatch_q <= 1'b0;
                        state_q    <= IDLE;
                    end else if (accept) begin
                        mismatch_q <= mismatch_d;
                        if (idx_q == 2'd3) begin
                            // Result is registered here so the pulse lands in the CHECK cycle
                            idx_q   <= 2'd0;
                            state_q <= CHECK;
                            if (mismatch_d) begin
                                fail_q     <= 1'b1;
                                fail_cnt_q <= fail_cnt_inc;
                            end else begin
                                unlock_q   <= 1'b1;
                                fail_cnt_q <= 4'd0;
                            end
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                CHECK: begin
                    mismatch_q <= 1'b0;
                    if (mismatch_q && (fail_cnt_q == FAIL_TRIP)) begin
                        state_q   <= LOCKOUT;
                        lockout_q <= 1'b1;
                        tmr_q     <= TMR_LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOCKOUT: begin
                    if (tmr_q == '0) begin
                        state_q    <= IDLE;
                        lockout_q  <= 1'b0;
                        fail_cnt_q <= 4'd0;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unlock_key_checker.sv
`timescale 1ns/1ps
// Directed bench for unlock_key_checker with default parameters
// (KEY A5C30F96, MAX_FAIL 3, LOCKOUT_CYCLES 16).
module tb_unlock_key_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [7:0] key_data;
    logic       key_ready;
    logic       locked;
    logic       unlock;
    logic       fail;
    logic       lockout;
    logic [3:0] fail_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    unlock_key_checker dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_data  (key_data),
        .key_ready (key_ready),
        .locked    (locked),
        .unlock    (unlock),
        .fail      (fail),
        .lockout   (lockout),
        .fail_cnt  (fail_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives the four key bytes on negedges (optionally with idle gaps) and
    // returns at the negedge of the cycle following the 4th accept.
    task automatic send_key(input logic [31:0] k, input int gap);
        for (int i = 0; i < 4; i++) begin
            if (i > 0 && gap > 0) begin
                @(negedge clk);
                key_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
            @(negedge clk);
            key_valid = 1'b1;
            key_data  = k[31-8*i -: 8];
        end
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic attempt(input string tag, input logic [31:0] k, input int gap,
                           input logic exp_unlock, input logic [3:0] exp_cnt,
                           input logic exp_lockout);
        send_key(k, gap);
        chk({tag, "_unlock"},   unlock,   exp_unlock);
        chk({tag, "_fail"},     fail,     !exp_unlock);
        chk({tag, "_fail_cnt"}, fail_cnt, exp_cnt);
        @(negedge clk);
        chk({tag, "_unlock_end"}, unlock,    1'b0);
        chk({tag, "_fail_end"},   fail,      1'b0);
        chk({tag, "_lockout"},    lockout,   exp_lockout);
        chk({tag, "_ready"},      key_ready, !exp_lockout);
    endtask

    // Called at the first lockout cycle; offers bytes throughout and counts its length
    task automatic measure_lockout(input string tag);
        int   n;
        logic saw_ready;
        n         = 0;
        saw_ready = 1'b0;
        for (int c = 0; c < 40 && lockout; c++) begin
            n++;
            if (key_ready) saw_ready = 1'b1;
            key_valid = 1'b1;
            key_data  = 8'hA5;
            @(negedge clk);
        end
        key_valid = 1'b0;
        chk({tag, "_len"},        n,         16);
        chk({tag, "_ready_in"},   saw_ready, 1'b0);
        chk({tag, "_ready_out"},  key_ready, 1'b1);
        chk({tag, "_cnt_out"},    fail_cnt,  4'd0);
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_data  = 8'h00;
        locked    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", key_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", key_ready, 1'b1);
        chk("rst_unlock",      unlock,    1'b0);
        chk("rst_fail",        fail,      1'b0);
        chk("rst_lockout",     lockout,   1'b0);
        chk("rst_fail_cnt",    fail_cnt,  4'd0);

        // correct key back-to-back, then a single wrong byte
        attempt("good",  32'hA5C3_0F96, 0, 1'b1, 4'd0, 1'b0);
        attempt("bad1",  32'hA5C3_0F97, 0, 1'b0, 4'd1, 1'b0);

        // three consecutive failures trip the lockout; bytes offered in it are ignored
        attempt("bad2",  32'h0011_2233, 0, 1'b0, 4'd2, 1'b0);
        attempt("bad3",  32'h1234_5678, 0, 1'b0, 4'd3, 1'b1);
        measure_lockout("lock");
        attempt("post_lock", 32'hA5C3_0F96, 0, 1'b1, 4'd0, 1'b0);

        // two failures then the right key, sent with gaps between bytes
        attempt("two_a", 32'h25C3_0F96, 0, 1'b0, 4'd1, 1'b0);
        attempt("two_b", 32'hA5C3_8F96, 0, 1'b0, 4'd2, 1'b0);
        attempt("two_ok", 32'hA5C3_0F96, 2, 1'b1, 4'd0, 1'b0);

        // partial attempt aborted by locked=0; fail count survives the abort
        attempt("pre_part", 32'hFFFF_FFFF, 0, 1'b0, 4'd1, 1'b0);
        @(negedge clk);
        key_valid = 1'b1;
        key_data  = 8'hA5;
        @(negedge clk);
        key_data  = 8'hC3;
        @(negedge clk);
        key_valid = 1'b0;
        locked    = 1'b0;
        #1;
        chk("unlocked_ready", key_ready, 1'b0);
        @(negedge clk);
        locked = 1'b1;
        chk("part_fail_cnt", fail_cnt, 4'd1);
        chk("part_unlock",   unlock,   1'b0);
        attempt("after_part", 32'hA5C3_0F96, 0, 1'b1, 4'd0, 1'b0);

        // reset in the 5th lockout cycle ends the lockout at once
        attempt("r_bad1", 32'h0000_0000, 0, 1'b0, 4'd1, 1'b0);
        attempt("r_bad2", 32'hA5C3_0F00, 0, 1'b0, 4'd2, 1'b0);
        attempt("r_bad3", 32'hA5C3_0096, 0, 1'b0, 4'd3, 1'b1);
        repeat (4) @(negedge clk);
        chk("r_lock_c5", lockout, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("r_lockout", lockout,   1'b0);
        chk("r_cnt",     fail_cnt,  4'd0);
        chk("r_ready",   key_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("r_ready_after", key_ready, 1'b1);
        attempt("r_good", 32'hA5C3_0F96, 0, 1'b1, 4'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
